// File: rtl/cache_pkg.sv
// Shared state type and block geometry for the cache fill path.
package cache_pkg;

   typedef enum logic {IDLE, FILL} state_e;

   localparam int unsigned WORDS_PER_BLOCK   = 8;
   localparam int unsigned BLOCK_OFFSET_BITS = $clog2(2 * WORDS_PER_BLOCK);
   localparam int unsigned WORD_SEL_W        = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear (priority over enable) and async active-low reset.
module fill_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill initiator: issues pipelined word reads on a miss, writes returning words into
// the data array, and forwards write-through stores to memory while idle.
module cache_fill_fsm #(
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int unsigned MEM_LAT         = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               miss_detected,
   input  logic [ADDR_WIDTH-1:0]              miss_address,
   input  logic                               wr_req,
   input  logic [ADDR_WIDTH-1:0]              wr_addr,
   input  logic [15:0]                        wr_data,
   output logic                               fsm_busy,
   output logic                               mem_enable,
   output logic                               mem_wr,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic [15:0]                        mem_data_out,
   input  logic [15:0]                        mem_data_in,
   input  logic                               mem_data_valid,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_sel,
   output logic [15:0]                        write_data,
   output logic                               write_tag_array,
   output logic                               fill_done
);

   localparam int unsigned SEL_W = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned CNT_W = SEL_W + 1;
   localparam int unsigned OFF_W = $clog2(2 * WORDS_PER_BLOCK);
   localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

   cache_pkg::state_e     state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      issue_cnt, ret_cnt;
   logic                  cnt_clr, issue_en, ret_en;

   // Memory latency is fixed by the memory; the FSM simply counts returns as they arrive.
   logic unused_mem_lat;
   assign unused_mem_lat = ^MEM_LAT;

   fill_counter #(
      .WIDTH(CNT_W)
   ) u_issue_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .en   (issue_en),
      .cnt  (issue_cnt)
   );

   fill_counter #(
      .WIDTH(CNT_W)
   ) u_ret_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .en   (ret_en),
      .cnt  (ret_cnt)
   );

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      cnt_clr          = 1'b0;
      issue_en         = 1'b0;
      ret_en           = 1'b0;
      fsm_busy         = 1'b0;
      mem_enable       = 1'b0;
      mem_wr           = 1'b0;
      mem_addr         = '0;
      mem_data_out     = '0;
      write_data_array = 1'b0;
      data_word_sel    = '0;
      write_data       = '0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;

      unique case (state_q)
         cache_pkg::IDLE: begin
            fsm_busy = miss_detected;
            if (miss_detected) begin
               state_d = cache_pkg::FILL;
               base_d  = miss_address & BLOCK_MASK;
               cnt_clr = 1'b1;
            end else if (wr_req) begin
               mem_enable   = 1'b1;
               mem_wr       = 1'b1;
               mem_addr     = wr_addr;
               mem_data_out = wr_data;
            end
         end
         cache_pkg::FILL: begin
            fsm_busy = 1'b1;
            if (issue_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
               mem_enable = 1'b1;
               mem_addr   = base_q + ADDR_WIDTH'({issue_cnt, 1'b0});
               issue_en   = 1'b1;
            end
            if (mem_data_valid) begin
               write_data_array = 1'b1;
               data_word_sel    = ret_cnt[SEL_W-1:0];
               write_data       = mem_data_in;
               ret_en           = 1'b1;
               if (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                  write_tag_array = 1'b1;
                  fill_done       = 1'b1;
                  state_d         = cache_pkg::IDLE;
               end
            end
         end
         default: state_d = cache_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= cache_pkg::IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

endmodule
